// File: rtl/sfp_pkg.sv
// Shared constants and FSM state type for the peer row-sum reader.
//   BW      : activation bit width
//   BW_PSUM : partial-sum width
//   SUM_W   : row-sum width carried between cores
//   state_e : reader FSM states (IDLE, RD, CAP)
package sfp_pkg;

  localparam int unsigned BW      = 8;
  localparam int unsigned BW_PSUM = 2 * BW + 4;
  localparam int unsigned SUM_W   = BW_PSUM + 4;
  localparam int unsigned RX_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_buf.sv
// Local row-sum buffer: synchronous DEPTH x SUM_W FIFO.
// Ports:
//   clk, reset_n      : clock, async active-low reset (pointers/count only)
//   flush             : synchronous clear of pointers and count
//   push, push_data   : write tail at end of cycle
//   pop               : drop head at end of cycle (ignored when empty)
//   count             : registered occupancy, 0..DEPTH
//   head_c            : head entry when non-empty, zero when empty
module sum_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SUM_W = sfp_pkg::SUM_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [SUM_W-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [SUM_W-1:0]         head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [SUM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;
  logic             empty;
  logic             full;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign count  = cnt;
  assign head_c = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/peer_sum_reader.sv
// Pulls row sums from a peer core's FIFO into a local buffer that feeds the
// 2-core sum adder and divide step.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   peer_nonempty  : peer FIFO holds data
//   peer_sum       : peer FIFO head, valid the cycle after peer_rd
//   peer_rd        : single-cycle read strobe to the peer FIFO
//   div_req        : divide step consumes the buffer head
//   flush          : synchronous clear of buffer and FSM
//   sum_in         : buffer head (zero when empty)
//   ready_to_div   : buffer non-empty
//   err_underflow  : sticky, div_req seen with an empty buffer
//   rx_count       : captured-sum counter, only with PEER_SUM_STAT_EN, else 0
// Build option: define PEER_SUM_STAT_EN to enable rx_count.
module peer_sum_reader import sfp_pkg::*; #(
  parameter int unsigned BW      = sfp_pkg::BW,
  parameter int unsigned BW_PSUM = 2 * BW + 4,
  parameter int unsigned SUM_W   = BW_PSUM + 4,
  parameter int unsigned DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             peer_nonempty,
  input  logic [SUM_W-1:0] peer_sum,
  output logic             peer_rd,
  input  logic             div_req,
  input  logic             flush,
  output logic [SUM_W-1:0] sum_in,
  output logic             ready_to_div,
  output logic             err_underflow,
  output logic [15:0]      rx_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] count;
  logic          push;
  logic          room_idle;
  logic          room_cap;

  // A slot is reserved on entry to RD, so the occupancy seen in CAP still
  // excludes the sum being captured; count it when deciding to read again.
  assign room_idle = (count < CW'(DEPTH));
  assign room_cap  = ((count + CW'(1)) < CW'(DEPTH));

  // Capture happens in CAP; a coincident flush discards it.
  assign push = (state == CAP) && !flush;

  // State register plus registered read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      peer_rd <= 1'b0;
    end else begin
      state   <= state_nxt;
      peer_rd <= (state_nxt == RD);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (peer_nonempty && room_idle) state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = (peer_nonempty && room_cap) ? RD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Sticky underflow flag; flush does not clear it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     err_underflow <= 1'b0;
    else if (div_req && count == '0)  err_underflow <= 1'b1;
  end

  sum_buf #(
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (peer_sum),
    .pop       (div_req),
    .count     (count),
    .head_c    (sum_in)
  );

  assign ready_to_div = (count != '0);

`ifdef PEER_SUM_STAT_EN
  // Count of accepted captures, free-running with wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rx_count <= '0;
    else if (push) rx_count <= rx_count + 16'd1;
  end
`else
  assign rx_count = '0;
`endif

endmodule

// File: tb/tb_peer_sum_reader.sv
// Self-checking bench for peer_sum_reader: the bench plays the peer FIFO and
// keeps a queue-level model of the local buffer.
module tb_peer_sum_reader;

  localparam int unsigned SUM_W = 24;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             peer_nonempty = 1'b0;
  logic [SUM_W-1:0] peer_sum = '0;
  logic             peer_rd;
  logic             div_req = 1'b0;
  logic             flush = 1'b0;
  logic [SUM_W-1:0] sum_in;
  logic             ready_to_div;
  logic             err_underflow;
  logic [15:0]      rx_count;

  always #5 clk = ~clk;

  peer_sum_reader #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .peer_nonempty (peer_nonempty),
    .peer_sum      (peer_sum),
    .peer_rd       (peer_rd),
    .div_req       (div_req),
    .flush         (flush),
    .sum_in        (sum_in),
    .ready_to_div  (ready_to_div),
    .err_underflow (err_underflow),
    .rx_count      (rx_count)
  );

  // Peer FIFO contents and expected local buffer contents.
  logic [SUM_W-1:0] peer_q[$];
  logic [SUM_W-1:0] exp_q[$];
  logic             exp_rd;
  logic             exp_cap;
  logic             exp_err;
  int               exp_rx;
  int               checks;
  int               failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_peer_rd"}, 32'(peer_rd), 32'(exp_rd));
    check({tag, "_ready"}, 32'(ready_to_div), 32'(exp_q.size() != 0));
    check({tag, "_sum_in"}, 32'(sum_in), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check({tag, "_err"}, 32'(err_underflow), 32'(exp_err));
`ifdef PEER_SUM_STAT_EN
    check({tag, "_rx"}, 32'(rx_count), 32'(exp_rx) & 32'hFFFF);
`else
    check({tag, "_rx"}, 32'(rx_count), 32'd0);
`endif
  endtask

  task automatic add_peer(input logic [SUM_W-1:0] v);
    peer_q.push_back(v);
    peer_nonempty = 1'b1;
  endtask

  // One clock: predict from the reader rules, advance, play the peer, compare.
  task automatic cycle();
    logic             rd_seen;
    logic             room;
    logic             nxt_rd;
    logic             nxt_cap;
    logic [SUM_W-1:0] tmp;
    int               sz;
    rd_seen = peer_rd;
    sz      = exp_q.size();
    room    = exp_cap ? (sz + 1 < DEPTH) : (sz < DEPTH);
    nxt_rd  = !flush && !exp_rd && peer_nonempty && room;
    nxt_cap = !flush && exp_rd;
    if (div_req && sz == 0) exp_err = 1'b1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (div_req && sz != 0) tmp = exp_q.pop_front();
      if (exp_cap) begin
        exp_q.push_back(peer_sum);
        exp_rx++;
      end
    end
    exp_rd  = nxt_rd;
    exp_cap = nxt_cap;
    @(posedge clk);
    #1;
    if (rd_seen && peer_q.size() != 0) peer_sum = peer_q.pop_front();
    else                               peer_sum = SUM_W'($urandom);
    peer_nonempty = (peer_q.size() != 0);
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    div_req = 1'b0;
    flush   = 1'b0;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_rd  = 1'b0;
    exp_cap = 1'b0;
    exp_err = 1'b0;
    exp_rx  = 0;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold");
    reset_n = 1'b1;
  endtask

  task automatic wait_rd(input string tag);
    for (int i = 0; i < 20 && peer_rd !== 1'b1; i++) cycle();
    check({tag, "_rd_timeout"}, 32'(peer_rd), 32'd1);
  endtask

  initial begin
    logic [SUM_W-1:0] vals [5];
    int               rx_before;
    checks   = 0;
    failures = 0;
    exp_rd   = 1'b0;
    exp_cap  = 1'b0;
    exp_err  = 1'b0;
    exp_rx   = 0;
    #1;
    do_reset();

    // Single transfer: strobe on the first cycle, value lands two cycles later.
    add_peer(24'h000123);
    cycle();
    check("single_rd_pulse", 32'(peer_rd), 32'd1);
    cycle();
    check("single_rd_gap", 32'(peer_rd), 32'd0);
    cycle();
    check("single_sum_in", 32'(sum_in), 32'h000123);
    check("single_ready", 32'(ready_to_div), 32'd1);
    div_req = 1'b1;
    cycle();
    div_req = 1'b0;
    check("single_drained", 32'(ready_to_div), 32'd0);

    // Ten peer sums, no consumption: exactly DEPTH are read.
    for (int v = 1; v <= 10; v++) add_peer(SUM_W'(v));
    for (int i = 0; i < 30; i++) cycle();
    check("fill_peer_left", 32'(peer_q.size()), 32'd2);
    check("fill_rd_stopped", 32'(peer_rd), 32'd0);
    check("fill_ready", 32'(ready_to_div), 32'd1);
    for (int v = 1; v <= 8; v++) begin
      check("fill_order", 32'(sum_in), 32'(v));
      div_req = 1'b1;
      cycle();
      div_req = 1'b0;
    end
    for (int i = 0; i < 10; i++) cycle();
    check("fill_resume_peer", 32'(peer_q.size()), 32'd0);
    check("fill_resume_head", 32'(sum_in), 32'd9);
    div_req = 1'b1;
    cycle();
    check("fill_resume_tail", 32'(sum_in), 32'd10);
    cycle();
    div_req = 1'b0;
    check("fill_empty", 32'(ready_to_div), 32'd0);

    // Underflow is sticky and leaves the head at zero.
    div_req = 1'b1;
    cycle();
    div_req = 1'b0;
    check("uflow_set", 32'(err_underflow), 32'd1);
    check("uflow_sum_zero", 32'(sum_in), 32'd0);
    repeat (3) cycle();
    check("uflow_sticky", 32'(err_underflow), 32'd1);
    do_reset();
    check("uflow_cleared", 32'(err_underflow), 32'd0);

    // Push and pop in the same cycle at four entries.
    for (int i = 0; i < 5; i++) vals[i] = SUM_W'($urandom);
    for (int i = 0; i < 4; i++) add_peer(vals[i]);
    for (int i = 0; i < 12; i++) cycle();
    check("simul_head0", 32'(sum_in), 32'(vals[0]));
    add_peer(vals[4]);
    wait_rd("simul");
    cycle();
    div_req = 1'b1;
    cycle();
    div_req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check("simul_order", 32'(sum_in), 32'(vals[i]));
      div_req = 1'b1;
      cycle();
      div_req = 1'b0;
    end
    check("simul_drained", 32'(ready_to_div), 32'd0);

    // Flush coinciding with a capture discards it and empties the buffer.
    add_peer(SUM_W'($urandom));
    add_peer(SUM_W'($urandom));
    for (int i = 0; i < 8; i++) cycle();
    check("flush_pre_ready", 32'(ready_to_div), 32'd1);
    rx_before = exp_rx;
    add_peer(24'hABCDEF);
    wait_rd("flush");
    cycle();
    check("flush_cap_data", 32'(peer_sum), 32'hABCDEF);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_ready", 32'(ready_to_div), 32'd0);
    check("flush_sum_zero", 32'(sum_in), 32'd0);
`ifdef PEER_SUM_STAT_EN
    check("flush_rx_kept", 32'(rx_count), 32'(rx_before) & 32'hFFFF);
`else
    check("flush_rx_kept", 32'(rx_count), 32'd0);
`endif
    repeat (4) cycle();
    check("flush_nothing_stored", 32'(ready_to_div), 32'd0);

    // Reset dropped in the middle of an RD cycle.
    add_peer(SUM_W'($urandom));
    wait_rd("rst_mid");
    #2;
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    check("rst_mid_reread", 32'(ready_to_div), 32'd1);

    // Randomized traffic: filling phase then draining phase.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) add_peer(SUM_W'($urandom));
      div_req = ($urandom_range(0, 9) < ((i < 200) ? 2 : 6));
      flush   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    div_req = 1'b0;
    flush   = 1'b0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
